// File: rtl/interval_meter_pkg.sv
// Shared definitions for interval_meter: FSM state encodings and the
// default parameter values for the result width and the prescale ratio.
package interval_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned N_DEFAULT        = 8;
  localparam int unsigned PRESCALE_DEFAULT = 1;

endpackage

// File: rtl/interval_meter_tick.sv
// tick_gen: divides enabled clock cycles by PRESCALE.
//   clk      - clock
//   rst      - asynchronous active-high reset
//   en       - advance the prescaler this edge
//   sync_clr - synchronous zero of the prescaler (wins over en)
//   tick     - high on an enabled cycle where the prescaler is at PRESCALE-1
// For PRESCALE=1 the counter is pinned at 0, so tick == en.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (sync_clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == LAST) pcnt <= '0;
      else              pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_meter.sv
// interval_meter: measures the number of PRESCALE-cycle periods between a
// start and a stop, saturating at 2^n-1 with a sticky overflow flag.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - begin / restart a measurement
//   stop  - end the measurement
//   clear - synchronous return to idle, result discarded
//   count - running value while busy, held result while valid
//   valid - a completed result is held
//   busy  - measuring
//   ovf   - sticky saturation flag
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int unsigned n        = N_DEFAULT,
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  output logic [n-1:0] count,
  output logic         valid,
  output logic         busy,
  output logic         ovf
);

  state_t state;
  logic   tick;
  logic   run_adv;
  logic   pre_clr;

  // The prescaler advances on every RUN edge that is not overridden by
  // clear or by a restart; a stop edge still advances it.
  assign run_adv = (state == RUN) && !clear && (stop || !start);
  // Zero the prescaler on clear or on any start that is not a RUN stop.
  assign pre_clr = clear || (start && !((state == RUN) && stop));

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (run_adv),
    .sync_clr (pre_clr),
    .tick     (tick)
  );

  assign busy  = (state == RUN);
  assign valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop || !start) begin
            if (stop) state <= DONE;
            if (tick) begin
              if (count == '1) ovf   <= 1'b1;
              else             count <= count + 1'b1;
            end
          end else begin
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            state <= stop ? DONE : RUN;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_meter.sv
module tb_interval_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;

  logic [7:0] c8;  logic v8, b8, o8;
  logic [3:0] c4;  logic v4, b4, o4;
  logic [7:0] cp;  logic vp, bp, op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  interval_meter #(.n(8), .PRESCALE(1)) u8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .count(c8), .valid(v8), .busy(b8), .ovf(o8));

  interval_meter #(.n(4), .PRESCALE(1)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .count(c4), .valid(v4), .busy(b4), .ovf(o4));

  interval_meter #(.n(8), .PRESCALE(4)) up (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .count(cp), .valid(vp), .busy(bp), .ovf(op));

  // One edge with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #2;
    tests++; if (c8 !== 8'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", c8); end
    tests++; if ({v8, b8, o8} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {v8, b8, o8}); end
    tests++; if ({c4, v4, b4, o4} !== 7'd0) begin fails++; $display("FAIL reset_u4 got %h exp 0", {c4, v4, b4, o4}); end
    tests++; if ({cp, vp, bp, op} !== 11'd0) begin fails++; $display("FAIL reset_up got %h exp 0", {cp, vp, bp, op}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_stop;
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if ({c8, v8, b8} !== 10'd0) begin fails++; $display("FAIL idle_stop got %h exp 0", {c8, v8, b8}); end
  endtask

  task automatic test_basic;
    int bad;
    cyc(1'b1, 1'b0, 1'b0);
    tests++; if (c8 !== 8'd0 || b8 !== 1'b1) begin fails++; $display("FAIL basic_start got count=%0d busy=%b exp 0/1", c8, b8); end
    idle(4);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (c8 !== 8'd5) begin fails++; $display("FAIL basic_count got %0d exp 5", c8); end
    tests++; if ({v8, b8, o8} !== 3'b100) begin fails++; $display("FAIL basic_flags got %b exp 100", {v8, b8, o8}); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (c8 !== 8'd5 || v8 !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL basic_hold got %0d bad cycles exp 0", bad); end
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (c8 !== 8'd5 || v8 !== 1'b1) begin fails++; $display("FAIL done_stop got count=%0d valid=%b exp 5/1", c8, v8); end
  endtask

  task automatic test_saturate;
    cyc(1'b1, 1'b0, 1'b0);
    idle(19);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (c4 !== 4'd15) begin fails++; $display("FAIL sat_count got %0d exp 15", c4); end
    tests++; if ({o4, v4, b4} !== 3'b110) begin fails++; $display("FAIL sat_flags got %b exp 110", {o4, v4, b4}); end
    tests++; if (c8 !== 8'd20) begin fails++; $display("FAIL sat_u8 got %0d exp 20", c8); end
    idle(2);
    tests++; if (o4 !== 1'b1) begin fails++; $display("FAIL sat_sticky got %b exp 1", o4); end
    cyc(1'b1, 1'b0, 1'b0);
    tests++; if ({c4, o4, b4} !== 6'b000001) begin fails++; $display("FAIL sat_restart got count=%0d ovf=%b busy=%b exp 0/0/1", c4, o4, b4); end
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_prescale;
    cyc(1'b1, 1'b0, 1'b0);
    idle(9);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (cp !== 8'd2 || vp !== 1'b1) begin fails++; $display("FAIL pre_k10 got count=%0d valid=%b exp 2/1", cp, vp); end
    tests++; if (c8 !== 8'd10) begin fails++; $display("FAIL pre_u8 got %0d exp 10", c8); end
    cyc(1'b1, 1'b0, 1'b0);
    idle(11);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (cp !== 8'd3) begin fails++; $display("FAIL pre_k12 got %0d exp 3", cp); end
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (cp !== 8'd0 || vp !== 1'b1) begin fails++; $display("FAIL pre_k3 got count=%0d valid=%b exp 0/1", cp, vp); end
  endtask

  task automatic test_same_edge;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    tests++; if ({c8, v8, b8} !== 10'b0000000010) begin fails++; $display("FAIL same_edge got count=%0d valid=%b busy=%b exp 0/1/0", c8, v8, b8); end
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (c8 !== 8'd3) begin fails++; $display("FAIL pre_clear got %0d exp 3", c8); end
    cyc(1'b1, 1'b0, 1'b1);
    tests++; if ({c8, v8, b8} !== 10'd0) begin fails++; $display("FAIL clear_start got count=%0d valid=%b busy=%b exp 0/0/0", c8, v8, b8); end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 1'b0);
    idle(7);
    tests++; if (c8 !== 8'd7 || b8 !== 1'b1) begin fails++; $display("FAIL ar_pre got count=%0d busy=%b exp 7/1", c8, b8); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({c8, v8, b8} !== 10'd0) begin fails++; $display("FAIL ar_async got count=%0d valid=%b busy=%b exp 0/0/0", c8, v8, b8); end
    #1 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0);
    tests++; if (c8 !== 8'd3 || v8 !== 1'b1) begin fails++; $display("FAIL ar_after got count=%0d valid=%b exp 3/1", c8, v8); end
  endtask

  task automatic test_restart;
    cyc(1'b1, 1'b0, 1'b0);
    idle(9);
    tests++; if (c8 !== 8'd9) begin fails++; $display("FAIL rs_pre got %0d exp 9", c8); end
    cyc(1'b1, 1'b0, 1'b0);
    tests++; if (c8 !== 8'd0 || b8 !== 1'b1) begin fails++; $display("FAIL rs_zero got count=%0d busy=%b exp 0/1", c8, b8); end
    idle(1);
    tests++; if (c8 !== 8'd1) begin fails++; $display("FAIL rs_one got %0d exp 1", c8); end
    idle(5);
    cyc(1'b1, 1'b1, 1'b0);
    tests++; if (c8 !== 8'd7 || v8 !== 1'b1) begin fails++; $display("FAIL stop_over_start got count=%0d valid=%b exp 7/1", c8, v8); end
    cyc(1'b1, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 1'b1);
    tests++; if ({c8, v8, b8} !== 10'd0) begin fails++; $display("FAIL clear_stop got count=%0d valid=%b busy=%b exp 0/0/0", c8, v8, b8); end
  endtask

  initial begin
    test_reset();
    test_ignore_stop();
    test_basic();
    test_saturate();
    test_prescale();
    test_same_edge();
    test_async_reset();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 The block SHALL have parameter n, default 8, the result counter width in bits.
REQ-002 The block SHALL have parameter PRESCALE, default 1, the clock cycles per result count (legal range 1..256).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, which begins or restarts an interval measurement.
REQ-006 The block SHALL have port stop, input, 1, which ends the interval being measured.
REQ-007 The block SHALL have port clear, input, 1, a synchronous return to idle with the result discarded.
REQ-008 The block SHALL have port count, output, n, the running value while measuring and the held result once done.
REQ-009 The block SHALL have port valid, output, 1, high while a completed result is held.
REQ-010 The block SHALL have port busy, output, 1, high while measuring.
REQ-011 The block SHALL have port ovf, output, 1, a sticky saturation flag.

Function
REQ-012 The block SHALL implement an FSM with three states: IDLE, RUN and DONE; busy = (state==RUN) and valid = (state==DONE), both registered-state decodes.
REQ-013 Input priority in every state SHALL be clear > stop > start; a clear sampled at an edge SHALL move the block to IDLE with count=0 and ovf=0.
REQ-014 In IDLE, start alone SHALL move the block to RUN and zero count, the prescaler and ovf; stop alone SHALL be ignored.
REQ-015 In IDLE, start and stop sampled at the same edge SHALL move the block directly to DONE with count=0 and valid=1.
REQ-016 In RUN, every edge, including the edge that samples stop, SHALL advance the prescaler; when the prescaler is at PRESCALE-1 it SHALL wrap to 0 and count SHALL increment.
REQ-017 For a start sampled at edge E0 and a stop at edge Ek (k>=1), the held result SHALL equal floor(k/PRESCALE), saturated per REQ-018.
REQ-018 An increment with count = 2^n-1 SHALL leave count at 2^n-1 and set ovf to 1; ovf SHALL stay set until the next start or clear, or reset.
REQ-019 In RUN, stop SHALL move the block to DONE at that edge with the final value per REQ-016; start without stop SHALL restart the measurement (count, prescaler and ovf zeroed, state stays RUN).
REQ-020 In DONE, count and ovf SHALL hold; start SHALL behave as in IDLE (REQ-014/015), and stop alone SHALL be ignored.
REQ-021 count SHALL be a registered output with no combinational path from start, stop or clear.

Reset
REQ-022 rst asserted SHALL immediately, without waiting for a clock, force state=IDLE, count=0, prescaler=0, ovf=0, valid=0 and busy=0, including in the middle of a measurement.
REQ-023 The first edge after rst deasserts SHALL evaluate inputs normally, with no dead cycles.

Structure
REQ-024 A shared package SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default values of n and PRESCALE.
REQ-025 The prescaler SHALL be a sub-module, tick_gen, with ports clk, rst, en, sync_clr and tick, parameterised by PRESCALE; for PRESCALE=1 tick SHALL equal en.

Verification
REQ-026 With n=8 and PRESCALE=1: start at E10, stop at E15 -> count=5, valid=1, busy=0 from E15, ovf=0; the result SHALL hold for 20 idle cycles.
REQ-027 With n=4 and PRESCALE=1: start, then stop 20 edges later -> count=15, ovf=1, valid=1; a following start SHALL zero both count and ovf.
REQ-028 With n=8 and PRESCALE=4: start at E0, stop at E10 -> count=2; stop at E12 -> count=3.
REQ-029 Start and stop at the same edge in IDLE -> DONE with count=0 and valid=1; clear together with start -> IDLE with count=0.
REQ-030 Assert rst asynchronously (between edges) at RUN with count=7 -> count=0, busy=0 and valid=0 before the next edge; after rst deasserts, start then stop 3 edges later -> count=3.
REQ-031 In RUN at count=9: start alone -> count=1 one edge later; clear together with stop -> IDLE with count=0 and valid=0.
